// File: rtl/mcu_timer_bank_if.sv
// rtl/mcu_timer_bank_if.sv - command bus for the timer bank
//
// Purpose: bundles the count-enable strobe and the load/stop/clear command
// strobes driven by the CPU side into the timer bank.
// Ports (signals):
//   clk_en                     count enable (machine-cycle strobe)
//   ld_valid/ld_ch/ld_val      load/start command, channel, start/reload value
//   ld_mode/ld_ien             0 = one-shot / 1 = auto-reload, interrupt enable
//   stop_valid/stop_ch         stop command and channel
//   clr_valid/clr_ch           clear-flag command and channel
// Modports: master drives the commands, slave (the timer bank) receives them.
interface mcu_timer_bank_if #(
  parameter int CH_W  = 3,
  parameter int CNT_W = 6
);
  logic             clk_en;
  logic             ld_valid;
  logic [CH_W-1:0]  ld_ch;
  logic [CNT_W-1:0] ld_val;
  logic             ld_mode;
  logic             ld_ien;
  logic             stop_valid;
  logic [CH_W-1:0]  stop_ch;
  logic             clr_valid;
  logic [CH_W-1:0]  clr_ch;

  modport master (
    output clk_en, ld_valid, ld_ch, ld_val, ld_mode, ld_ien,
           stop_valid, stop_ch, clr_valid, clr_ch
  );

  modport slave (
    input clk_en, ld_valid, ld_ch, ld_val, ld_mode, ld_ien,
          stop_valid, stop_ch, clr_valid, clr_ch
  );
endinterface

// File: rtl/mcu_timer_bank.sv
// rtl/mcu_timer_bank.sv - bank of prescaled down-counting timer channels
//
// Purpose: CHANNELS independent timers. Each channel has a PRE_W-bit
// prescaler that wraps every 2^PRE_W enabled ticks and a CNT_W-bit main
// counter that decrements on each prescaler wrap. A channel loaded with value
// v expires (v+1)*2^PRE_W ticks after load, setting its tm flag; one-shot
// channels then stop, auto-reload channels reload and keep counting.
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   reset    in   synchronous active-high reset
//   cmd      in   command bus (mcu_timer_bank_if.slave)
//   tm       out  per-channel expiry flag (registered)
//   running  out  per-channel counting status (registered)
//   irq      out  registered OR over channels of (tm & ien)
module mcu_timer_bank #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 6,
  parameter int PRE_W    = 6,
  parameter int CH_W     = 3
) (
  input  logic                clk,
  input  logic                reset,
  mcu_timer_bank_if.slave     cmd,
  output logic [CHANNELS-1:0] tm,
  output logic [CHANNELS-1:0] running,
  output logic                irq
);

  logic [PRE_W-1:0]    pcount [CHANNELS];
  logic [CNT_W-1:0]    bcount [CNT_W > 0 ? CHANNELS : 1];
  logic [CNT_W-1:0]    reload [CHANNELS];
  logic [CHANNELS-1:0] mode;
  logic [CHANNELS-1:0] ien;

  logic [CHANNELS-1:0] ld_hit;
  logic [CHANNELS-1:0] stop_hit;
  logic [CHANNELS-1:0] clr_hit;
  logic [CHANNELS-1:0] expire;

  // Channel decode: an index >= CHANNELS matches no channel and is dropped.
  always_comb begin
    ld_hit   = '0;
    stop_hit = '0;
    clr_hit  = '0;
    expire   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ld_hit[i]   = cmd.ld_valid   && (cmd.ld_ch   == CH_W'(i));
      stop_hit[i] = cmd.stop_valid && (cmd.stop_ch == CH_W'(i));
      clr_hit[i]  = cmd.clr_valid  && (cmd.clr_ch  == CH_W'(i));
      // Final tick of a period: prescaler about to wrap with main count at 0.
      expire[i]   = running[i] && cmd.clk_en && (&pcount[i]) &&
                    (bcount[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pcount[i] <= '0;
        bcount[i] <= '0;
        reload[i] <= '0;
      end
      mode    <= '0;
      ien     <= '0;
      running <= '0;
      tm      <= '0;
      irq     <= 1'b0;
    end else begin
      // Built from the current flags so irq trails tm/ien by one clock.
      irq <= |(tm & ien);
      for (int i = 0; i < CHANNELS; i++) begin
        if (ld_hit[i]) begin
          pcount[i]  <= '0;
          bcount[i]  <= cmd.ld_val;
          reload[i]  <= cmd.ld_val;
          mode[i]    <= cmd.ld_mode;
          ien[i]     <= cmd.ld_ien;
          running[i] <= 1'b1;
          tm[i]      <= 1'b0;
        end else if (stop_hit[i]) begin
          // Stop beats the count on this edge: counters hold where they are.
          running[i] <= 1'b0;
        end else begin
          if (running[i] && cmd.clk_en) begin
            // Prescaler wraps naturally to 0, also on the expiry tick.
            pcount[i] <= pcount[i] + PRE_W'(1);
            if (&pcount[i]) begin
              if (bcount[i] != '0) begin
                bcount[i] <= bcount[i] - CNT_W'(1);
              end else begin
                tm[i] <= 1'b1;
                if (mode[i]) begin
                  bcount[i] <= reload[i];
                end else begin
                  running[i] <= 1'b0;
                end
              end
            end
          end
          // A clear landing on an expiry edge loses, so the event is not missed.
          if (clr_hit[i] && !expire[i]) begin
            tm[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mcu_timer_bank.sv
// tb/tb_mcu_timer_bank.sv - self-checking bench for mcu_timer_bank
module tb_mcu_timer_bank;

  localparam int CHANNELS = 2;
  localparam int CNT_W    = 6;
  localparam int PRE_W    = 2;
  localparam int CH_W     = 3;
  localparam int PRE_DIV  = 1 << PRE_W;

  logic                clk;
  logic                reset;
  logic [CHANNELS-1:0] tm;
  logic [CHANNELS-1:0] running;
  logic                irq;

  mcu_timer_bank_if #(.CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  mcu_timer_bank #(
    .CHANNELS(CHANNELS), .CNT_W(CNT_W), .PRE_W(PRE_W), .CH_W(CH_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cmd    (bus.slave),
    .tm     (tm),
    .running(running),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each channel is a countdown of ticks to expiry.
  logic [CHANNELS-1:0] m_tm, m_run, m_ien, m_mode;
  logic                m_irq;
  int                  m_rem    [CHANNELS];
  int                  m_period [CHANNELS];
  int                  m_val    [CHANNELS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic v, input logic [CH_W-1:0] ch, input int i);
    return v && (int'(ch) == i);
  endfunction

  task automatic model_step();
    logic fired;
    if (reset) begin
      m_tm = '0; m_run = '0; m_ien = '0; m_mode = '0; m_irq = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        m_rem[i] = 0; m_period[i] = 0; m_val[i] = 0;
      end
      return;
    end
    m_irq = |(m_tm & m_ien);
    for (int i = 0; i < CHANNELS; i++) begin
      if (hit(bus.ld_valid, bus.ld_ch, i)) begin
        m_val[i]    = int'(bus.ld_val);
        m_period[i] = (m_val[i] + 1) * PRE_DIV;
        m_rem[i]    = m_period[i];
        m_mode[i]   = bus.ld_mode;
        m_ien[i]    = bus.ld_ien;
        m_run[i]    = 1'b1;
        m_tm[i]     = 1'b0;
      end else if (hit(bus.stop_valid, bus.stop_ch, i)) begin
        m_run[i] = 1'b0;
      end else begin
        fired = 1'b0;
        if (m_run[i] && bus.clk_en) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            fired   = 1'b1;
            m_tm[i] = 1'b1;
            if (m_mode[i]) m_rem[i] = m_period[i];
            else           m_run[i] = 1'b0;
          end
        end
        if (hit(bus.clr_valid, bus.clr_ch, i) && !fired) m_tm[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("tm", 32'(tm), 32'(m_tm));
    chk("running", 32'(running), 32'(m_run));
    chk("irq", 32'(irq), 32'(m_irq));
    bus.ld_valid   = 1'b0;
    bus.stop_valid = 1'b0;
    bus.clr_valid  = 1'b0;
  endtask

  // One tick = one idle clk then one clk with clk_en high; ends on the tick edge.
  task automatic ticks(input int n);
    repeat (n) begin
      bus.clk_en = 1'b0; cycle();
      bus.clk_en = 1'b1; cycle();
    end
  endtask

  task automatic set_ld(input int ch, input int val, input logic md, input logic ie);
    bus.ld_valid = 1'b1;
    bus.ld_ch    = CH_W'(ch);
    bus.ld_val   = CNT_W'(val);
    bus.ld_mode  = md;
    bus.ld_ien   = ie;
  endtask

  task automatic set_clr(input int ch);
    bus.clr_valid = 1'b1;
    bus.clr_ch    = CH_W'(ch);
  endtask

  task automatic set_stop(input int ch);
    bus.stop_valid = 1'b1;
    bus.stop_ch    = CH_W'(ch);
  endtask

  initial begin
    int el;
    logic [CHANNELS-1:0] snap_run;
    reset = 1'b1;
    bus.clk_en = 1'b0; bus.ld_valid = 1'b0; bus.ld_ch = '0; bus.ld_val = '0;
    bus.ld_mode = 1'b0; bus.ld_ien = 1'b0; bus.stop_valid = 1'b0;
    bus.stop_ch = '0; bus.clr_valid = 1'b0; bus.clr_ch = '0;
    cycle(); cycle();
    chk("reset_tm", 32'(tm), 32'h0);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    cycle();

    // One-shot val=3: 16 ticks to expiry.
    set_ld(0, 3, 1'b0, 1'b0); cycle();
    ticks(15);
    chk("os_tm_tick15", 32'(tm[0]), 32'h0);
    ticks(1);
    chk("os_tm_tick16", 32'(tm[0]), 32'h1);
    chk("os_run_tick16", 32'(running[0]), 32'h0);
    ticks(4);
    chk("os_tm_held", 32'(tm[0]), 32'h1);

    // Auto-reload val=0 with interrupt.
    set_ld(1, 0, 1'b1, 1'b1); cycle();
    ticks(4);
    chk("ar_tm_tick4", 32'(tm[1]), 32'h1);
    chk("ar_irq_same_edge", 32'(irq), 32'h0);
    bus.clk_en = 1'b0; cycle();
    chk("ar_irq_next_clk", 32'(irq), 32'h1);
    set_clr(1); bus.clk_en = 1'b1; cycle();
    chk("ar_tm_clr_tick5", 32'(tm[1]), 32'h0);
    ticks(2);
    chk("ar_tm_tick7", 32'(tm[1]), 32'h0);
    ticks(1);
    chk("ar_tm_tick8", 32'(tm[1]), 32'h1);

    // Clear coincident with expiry keeps the flag.
    bus.clk_en = 1'b0; cycle();
    set_clr(1); bus.clk_en = 1'b1; cycle();
    chk("ar_tm_clr_tick9", 32'(tm[1]), 32'h0);
    ticks(2);
    bus.clk_en = 1'b0; cycle();
    set_clr(1); bus.clk_en = 1'b1; cycle();
    chk("clr_on_expiry_tm", 32'(tm[1]), 32'h1);
    bus.clk_en = 1'b0; cycle();
    chk("clr_on_expiry_irq", 32'(irq), 32'h1);

    // Reload on the expiry edge.
    set_ld(0, 3, 1'b0, 1'b0); cycle();
    ticks(15);
    bus.clk_en = 1'b0; cycle();
    set_ld(0, 1, 1'b0, 1'b0); bus.clk_en = 1'b1; cycle();
    chk("ld_on_expiry_tm", 32'(tm[0]), 32'h0);
    chk("ld_on_expiry_run", 32'(running[0]), 32'h1);
    ticks(7);
    chk("reload_tick7", 32'(tm[0]), 32'h0);
    ticks(1);
    chk("reload_tick8", 32'(tm[0]), 32'h1);

    // Stop mid-count freezes the counters.
    set_ld(0, 3, 1'b0, 1'b0); cycle();
    ticks(5);
    set_stop(0); bus.clk_en = 1'b0; cycle();
    el = m_period[0] - m_rem[0];
    chk("stop_pcount", 32'(dut.pcount[0]), 32'(el % PRE_DIV));
    chk("stop_bcount", 32'(dut.bcount[0]), 32'(m_val[0] - el / PRE_DIV));
    ticks(20);
    chk("stop_tm", 32'(tm[0]), 32'h0);
    chk("stop_run", 32'(running[0]), 32'h0);
    chk("stop_pcount_held", 32'(dut.pcount[0]), 32'h1);
    chk("stop_bcount_held", 32'(dut.bcount[0]), 32'h2);
    reset = 1'b1; cycle();
    reset = 1'b0;
    chk("rst_tm", 32'(tm), 32'h0);
    chk("rst_run", 32'(running), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    ticks(8);
    chk("post_rst_tm", 32'(tm), 32'h0);
    chk("post_rst_irq", 32'(irq), 32'h0);

    // Concurrent commands to different channels, then out-of-range commands.
    set_ld(1, 2, 1'b1, 1'b1); cycle();
    set_ld(0, 5, 1'b1, 1'b1); set_stop(1); cycle();
    chk("multi_run", 32'(running), 32'h1);
    set_ld(1, 1, 1'b0, 1'b0); cycle();
    snap_run = running;
    set_ld(2, 0, 1'b0, 1'b0); set_stop(3); set_clr(3); cycle();
    chk("bad_ch_run", 32'(running), 32'(snap_run));
    chk("bad_ch_tm", 32'(tm), 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      bus.clk_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0)
        set_ld($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) set_stop($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) set_clr($urandom_range(0, 3));
      reset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
